ccff_bitstream_loader: RTL and testbench



---
 rtl/ccff_bitstream_loader.sv | 129 ++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Purpose : serialises host bitstream words onto a configuration chain and
//           captures the bits leaving the chain tail as readback.
// Latency : first chain shift one cycle after the first accepted word; done one
//           cycle after the last shift. Backpressure: s_ready only while a word
//           slot is free; an empty word slot stalls the chain (not an error).
//
// Ports:
//   prog_clk, pReset          programming clock, synchronous active-high reset
//   start                     begin a load (sampled only in IDLE)
//   s_data/s_valid/s_ready    host word stream, MSB of s_data shifted first
//   ccff_head, ccff_tail      chain head (out) and chain tail (in)
//   cfg_shift_en              external prog_clk gate enable for the chain
//   rb_bit/rb_valid           readback of the chain's previous contents
//   busy, done                load in progress / one-cycle completion pulse
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_shift_en,
  output logic              rb_bit,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int BL_W    = $clog2(CHAIN_LEN + 1);
  localparam int WB_W    = $clog2(WORD_W + 1);
  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  localparam logic [BL_W-1:0] LEN_L   = BL_W'(CHAIN_LEN);
  localparam logic [BL_W-1:0] WORDS_L = BL_W'(N_WORDS);
  localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
  localparam logic [WB_W-1:0] WB_FULL = WB_W'(WORD_W);
  localparam logic [WB_W-1:0] WB_ONE  = WB_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [WB_W-1:0]   word_bits;
  logic [BL_W-1:0]   bits_left;
  logic [BL_W-1:0]   words_owed;
  logic              shift_act;
  logic              accept;

  // The chain shifts whenever the word slot still holds unshifted bits.
  assign shift_act = (state == SHIFT) && (word_bits != '0);
  // Masking with pReset keeps the gated clock from passing one more edge into
  // the fabric on the cycle the load is aborted.
  assign cfg_shift_en = shift_act && !pReset;
  assign ccff_head    = sreg[WORD_W-1];
  assign accept       = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        // Refill when the slot is empty, or as its last bit leaves, so that
        // consecutive words stream without a bubble.
        s_ready = (words_owed != '0) &&
                  ((word_bits == '0) || ((word_bits == WB_ONE) && shift_act));
        if (shift_act && (bits_left == BL_ONE)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state      <= IDLE;
      sreg       <= '0;
      word_bits  <= '0;
      bits_left  <= '0;
      words_owed <= '0;
      rb_bit     <= 1'b0;
      rb_valid   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rb_valid <= shift_act;
      if (shift_act) rb_bit <= ccff_tail;

      if ((state == IDLE) && start) begin
        bits_left  <= LEN_L;
        word_bits  <= '0;
        words_owed <= WORDS_L;
      end else if (state == SHIFT) begin
        if (shift_act) begin
          bits_left <= bits_left - BL_ONE;
          sreg      <= sreg << 1;
        end
        if (accept) begin
          sreg       <= s_data;
          word_bits  <= WB_FULL;
          words_owed <= words_owed - BL_ONE;
        end else if (shift_act) begin
          // On the final chain bit the unused low bits of a partial last
          // word are dropped by emptying the slot.
          if (bits_left == BL_ONE) word_bits <= '0;
          else                     word_bits <= word_bits - WB_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: three instances (8/4, 10/4, 37/8), each
// feeding a behavioural configuration chain clocked only when cfg_shift_en is
// high; directed vectors plus a randomized multi-load run.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_init;
  logic abort_a;

  // ---------------- instance A: CHAIN_LEN=8, WORD_W=4 ----------------
  logic       pr_a, start_a, vld_a, rdy_a, head_a, tail_a, en_a, rb_a, rbv_a, busy_a, done_a;
  logic [3:0] dat_a;
  assign pr_a = rst_init | abort_a;

  ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(4)) u_a (
    .prog_clk(clk), .pReset(pr_a), .start(start_a), .s_data(dat_a), .s_valid(vld_a),
    .s_ready(rdy_a), .ccff_head(head_a), .ccff_tail(tail_a), .cfg_shift_en(en_a),
    .rb_bit(rb_a), .rb_valid(rbv_a), .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: CHAIN_LEN=10, WORD_W=4 ----------------
  logic       start_b, vld_b, rdy_b, head_b, tail_b, en_b, rb_b, rbv_b, busy_b, done_b;
  logic [3:0] dat_b;

  ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_b (
    .prog_clk(clk), .pReset(rst_init), .start(start_b), .s_data(dat_b), .s_valid(vld_b),
    .s_ready(rdy_b), .ccff_head(head_b), .ccff_tail(tail_b), .cfg_shift_en(en_b),
    .rb_bit(rb_b), .rb_valid(rbv_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- instance C: CHAIN_LEN=37, WORD_W=8 ----------------
  logic       start_c, vld_c, rdy_c, head_c, tail_c, en_c, rb_c, rbv_c, busy_c, done_c;
  logic [7:0] dat_c;

  ccff_bitstream_loader #(.CHAIN_LEN(37), .WORD_W(8)) u_c (
    .prog_clk(clk), .pReset(rst_init), .start(start_c), .s_data(dat_c), .s_valid(vld_c),
    .s_ready(rdy_c), .ccff_head(head_c), .ccff_tail(tail_c), .cfg_shift_en(en_c),
    .rb_bit(rb_c), .rb_valid(rbv_c), .busy(busy_c), .done(done_c)
  );

  // ---------------- behavioural chains (gated prog_clk) ----------------
  logic [7:0]  chain_a;
  logic [9:0]  chain_b;
  logic [36:0] chain_c;
  assign tail_a = chain_a[7];
  assign tail_b = chain_b[9];
  assign tail_c = chain_c[36];

  always @(posedge clk) begin
    if (rst_init) begin
      chain_a <= 8'hC3;
      chain_b <= '0;
      chain_c <= '0;
    end else begin
      if (en_a) chain_a <= {chain_a[6:0], head_a};
      if (en_b) chain_b <= {chain_b[8:0], head_b};
      if (en_c) chain_c <= {chain_c[35:0], head_c};
    end
  end

  // ---------------- observation logs (sampled on falling edge) ----------------
  int sh_a, acc_a, dn_a, rbn_a;
  int sh_b, acc_b, dn_b, rbn_b;
  int sh_c, acc_c, dn_c, rbn_c;
  logic [63:0] hacc_a, racc_a, hacc_b, racc_b, hacc_c, racc_c;

  always @(negedge clk) begin
    if (en_a)  begin sh_a  <= sh_a + 1;  hacc_a <= {hacc_a[62:0], head_a}; end
    if (rbv_a) begin rbn_a <= rbn_a + 1; racc_a <= {racc_a[62:0], rb_a};   end
    if (vld_a && rdy_a) acc_a <= acc_a + 1;
    if (done_a) dn_a <= dn_a + 1;
    if (en_b)  begin sh_b  <= sh_b + 1;  hacc_b <= {hacc_b[62:0], head_b}; end
    if (rbv_b) begin rbn_b <= rbn_b + 1; racc_b <= {racc_b[62:0], rb_b};   end
    if (vld_b && rdy_b) acc_b <= acc_b + 1;
    if (done_b) dn_b <= dn_b + 1;
    if (en_c)  begin sh_c  <= sh_c + 1;  hacc_c <= {hacc_c[62:0], head_c}; end
    if (rbv_c) begin rbn_c <= rbn_c + 1; racc_c <= {racc_c[62:0], rb_c};   end
    if (vld_c && rdy_c) acc_c <= acc_c + 1;
    if (done_c) dn_c <= dn_c + 1;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // A full 8-bit load on instance A with s_valid held high from cycle 1;
  // words 0xA then 0x5. Extra start pulses are applied where start_mask says.
  task automatic load_a(input logic [15:0] start_mask);
    int widx;
    widx = 0;
    for (int c = 0; c < 16; c++) begin
      start_a = (c == 0) || start_mask[c];
      vld_a   = (c >= 1);
      dat_a   = (widx == 0) ? 4'hA : 4'h5;
      @(negedge clk);
      if (c == 10) check("a_done_cycle", 64'(done_a), 64'd1);
      if (c >= 11) check("a_idle_after_done", 64'({rdy_a, busy_a}), 64'd0);
      if (vld_a && rdy_a) widx++;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    vld_a   = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] w, input int gap);
    int t;
    vld_c = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    vld_c = 1'b1;
    dat_c = w;
    @(negedge clk);
    t = 0;
    while (!rdy_c && t < 100) begin @(negedge clk); t++; end
    check("c_accept", 64'(rdy_c), 64'd1);
    @(posedge clk); #1;
    vld_c = 1'b0;
  endtask

  typedef struct packed {
    logic       st;
    logic       vld;
    logic [3:0] dat;
    logic [5:0] exp;   // {s_ready, cfg_shift_en, ccff_head, busy, done, rb_valid}
    logic       rb;
  } vec_t;

  vec_t        vt [12];
  logic [3:0]  bw [3];
  int          sh0, acc0, dn0, rbn0, widx, t, starts;
  logic [39:0] cat;
  logic [36:0] cur, prev_c;
  logic [7:0]  w [5];

  initial begin
    //           st    vld   dat   exp        rb
    vt[0]  = {1'b1, 1'b0, 4'h0, 6'b000000, 1'b0};
    vt[1]  = {1'b0, 1'b1, 4'hA, 6'b100100, 1'b0};
    vt[2]  = {1'b0, 1'b1, 4'h5, 6'b011100, 1'b0};
    vt[3]  = {1'b0, 1'b1, 4'h5, 6'b010101, 1'b1};
    vt[4]  = {1'b0, 1'b1, 4'h5, 6'b011101, 1'b1};
    vt[5]  = {1'b0, 1'b1, 4'h5, 6'b110101, 1'b0};
    vt[6]  = {1'b0, 1'b1, 4'h5, 6'b010101, 1'b0};
    vt[7]  = {1'b0, 1'b1, 4'h5, 6'b011101, 1'b0};
    vt[8]  = {1'b0, 1'b1, 4'h5, 6'b010101, 1'b0};
    vt[9]  = {1'b0, 1'b1, 4'h5, 6'b011101, 1'b1};
    vt[10] = {1'b0, 1'b1, 4'h5, 6'b000011, 1'b1};
    vt[11] = {1'b0, 1'b1, 4'h5, 6'b000000, 1'b0};
    bw[0] = 4'hF; bw[1] = 4'h0; bw[2] = 4'hE;

    rst_init = 1'b1; abort_a = 1'b0;
    start_a = 1'b0; vld_a = 1'b0; dat_a = '0;
    start_b = 1'b0; vld_b = 1'b0; dat_b = '0;
    start_c = 1'b0; vld_c = 1'b0; dat_c = '0;
    repeat (3) @(posedge clk);
    #1 rst_init = 1'b0;

    // Reset state of every instance.
    @(negedge clk);
    check("reset_a", 64'({rdy_a, head_a, en_a, rb_a, rbv_a, busy_a, done_a}), 64'd0);
    check("reset_b", 64'({rdy_b, head_b, en_b, rb_b, rbv_b, busy_b, done_b}), 64'd0);
    check("reset_c", 64'({rdy_c, head_c, en_c, rb_c, rbv_c, busy_c, done_c}), 64'd0);
    @(posedge clk); #1;

    // Basic 8/4 load, cycle-accurate vectors; chain preloaded with 0xC3.
    for (int i = 0; i < 12; i++) begin
      start_a = vt[i].st; vld_a = vt[i].vld; dat_a = vt[i].dat;
      @(negedge clk);
      check($sformatf("vec%0d_outs", i),
            64'({rdy_a, en_a, head_a, busy_a, done_a, rbv_a}), 64'(vt[i].exp));
      if (vt[i].exp[0]) check($sformatf("vec%0d_rb", i), 64'(rb_a), 64'(vt[i].rb));
      @(posedge clk); #1;
    end
    start_a = 1'b0; vld_a = 1'b0;
    check("a_chain_final", 64'(chain_a), 64'h A5);
    check("a_rb_stream", 64'(racc_a[7:0]), 64'hC3);
    check("a_shift_count", 64'(sh_a), 64'd8);
    check("a_accepts", 64'(acc_a), 64'd2);
    check("a_done_count", 64'(dn_a), 64'd1);

    // Underrun: second word held back for five cycles.
    sh0 = sh_a; rbn0 = rbn_a;
    for (int c = 0; c < 12; c++) begin
      start_a = (c == 0);
      vld_a   = (c == 1) || (c == 10);
      dat_a   = (c == 1) ? 4'hA : 4'h5;
      @(negedge clk);
      if (c >= 6 && c <= 10) check("under_stall", 64'({rdy_a, en_a, head_a}), 64'b100);
      if (c >= 7 && c <= 11) check("under_no_rbv", 64'(rbv_a), 64'd0);
      @(posedge clk); #1;
    end
    start_a = 1'b0; vld_a = 1'b0;
    t = 0;
    while (!done_a && t < 20) begin @(posedge clk); #1; t++; end
    check("under_done", 64'(done_a), 64'd1);
    @(posedge clk); #1;
    check("under_shift_count", 64'(sh_a - sh0), 64'd8);
    check("under_rb_count", 64'(rbn_a - rbn0), 64'd8);
    check("under_chain", 64'(chain_a), 64'hA5);
    check("under_rb_stream", 64'(racc_a[7:0]), 64'hA5);
    check("under_head_stream", 64'(hacc_a[7:0]), 64'hA5);

    // Abort with pReset after three shifts.
    sh0 = sh_a;
    for (int c = 0; c < 6; c++) begin
      start_a = (c == 0);
      vld_a   = (c == 1);
      dat_a   = 4'hA;
      abort_a = (c == 5);
      @(posedge clk); #1;
    end
    abort_a = 1'b0; start_a = 1'b0; vld_a = 1'b0;
    check("abort_no_extra_shift", 64'(sh_a - sh0), 64'd3);
    @(negedge clk);
    check("abort_outputs", 64'({rdy_a, head_a, en_a, rb_a, rbv_a, busy_a, done_a}), 64'd0);
    @(posedge clk); #1;
    sh0 = sh_a; acc0 = acc_a; dn0 = dn_a; rbn0 = rbn_a;
    load_a(16'h0000);
    check("reload_shifts", 64'(sh_a - sh0), 64'd8);
    check("reload_accepts", 64'(acc_a - acc0), 64'd2);
    check("reload_done", 64'(dn_a - dn0), 64'd1);
    check("reload_rb_count", 64'(rbn_a - rbn0), 64'd8);
    check("reload_chain", 64'(chain_a), 64'hA5);

    // start pulses during SHIFT (cycle 3) and DONE (cycle 10) are ignored.
    sh0 = sh_a; acc0 = acc_a; dn0 = dn_a;
    load_a(16'h0408);
    check("ign_shifts", 64'(sh_a - sh0), 64'd8);
    check("ign_accepts", 64'(acc_a - acc0), 64'd2);
    check("ign_done", 64'(dn_a - dn0), 64'd1);
    check("ign_chain", 64'(chain_a), 64'hA5);

    // 10/4: three words, partial final word, s_valid held high throughout.
    widx = 0;
    for (int c = 0; c < 20; c++) begin
      start_b = (c == 0);
      vld_b   = (c >= 1);
      dat_b   = (widx < 3) ? bw[widx] : 4'h9;
      @(negedge clk);
      if (widx >= 3) check("b_ready_after_last", 64'(rdy_b), 64'd0);
      if (vld_b && rdy_b) widx++;
      @(posedge clk); #1;
    end
    start_b = 1'b0; vld_b = 1'b0;
    check("b_accepts", 64'(acc_b), 64'd3);
    check("b_shifts", 64'(sh_b), 64'd10);
    check("b_head_stream", 64'(hacc_b[9:0]), 64'b1111000011);
    check("b_chain", 64'(chain_b), 64'b1111000011);
    check("b_done", 64'(dn_b), 64'd1);
    check("b_rb_count", 64'(rbn_b), 64'd10);
    check("b_rb_stream", 64'(racc_b[9:0]), 64'd0);

    // 37/8 randomized: each load reads back the previous bitstream.
    prev_c = '0;
    starts = 0;
    for (int l = 0; l < 200; l++) begin
      for (int k = 0; k < 5; k++) begin
        w[k] = 8'($urandom_range(0, 255));
        cat  = {cat[31:0], w[k]};
      end
      cur = cat[39:3];
      sh0 = sh_c; acc0 = acc_c; dn0 = dn_c; rbn0 = rbn_c;
      start_c = 1'b1; starts++;
      @(posedge clk); #1;
      start_c = 1'b0;
      for (int k = 0; k < 5; k++) send_c(w[k], int'($urandom_range(0, 3)));
      t = 0;
      while (!done_c && t < 100) begin @(posedge clk); #1; t++; end
      check("c_done", 64'(done_c), 64'd1);
      @(posedge clk); #1;
      check("c_shift_count", 64'(sh_c - sh0), 64'd37);
      check("c_accepts", 64'(acc_c - acc0), 64'd5);
      check("c_head_stream", 64'(hacc_c[36:0]), 64'(cur));
      check("c_rb_count", 64'(rbn_c - rbn0), 64'd37);
      check("c_rb_stream", 64'(racc_c[36:0]), 64'(prev_c));
      prev_c = cur;
    end
    check("c_done_vs_start", 64'(dn_c), 64'(starts));
    check("c_chain_final", 64'(chain_c), 64'(prev_c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks made", n_chk);
    $fatal(1);
  end

endmodule
